// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and types
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;

  localparam int FCR_FIFO_EN  = 0;
  localparam int FCR_FIFO_CLR = 2;
  localparam int FCR_DMA_MODE = 3;

  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  typedef enum logic {
    DMA_MODE0 = 1'b0,
    DMA_MODE1 = 1'b1
  } uart_dma_mode_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - generic single-clock FIFO with FWFT head, level and clear
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Storage is deliberately left unreset; the level gates what is visible.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wdata;
  end

  assign rdata = (level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - THR holding FIFO with mode/clear control, LSR status and TXDRDYn
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int DATA_W = 8
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   i_wr_en,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic                   i_fifo_en,
  input  logic                   i_fifo_clr,
  input  logic                   i_dma_mode,
  input  logic                   i_tx_ready,
  input  logic                   i_tx_busy,
  output logic                   o_tx_valid,
  output logic [DATA_W-1:0]      o_tx_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_tx_fifo_empty,
  output logic                   o_tx_empty,
  output logic                   o_wr_overflow,
  output logic                   TXDRDYn
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic           fifo_en_q;
  logic           clr;
  logic           push;
  logic           pop;
  logic [LW-1:0]  level;
  logic [LW-1:0]  eff_depth;
  logic [LW-1:0]  next_level;
  logic           txdrdyn_d;
  uart_dma_mode_e dma_mode;

  assign eff_depth = i_fifo_en ? LW'(DEPTH) : LW'(1);
  // Toggling FIFO enable flushes the buffer, same as an explicit FCR clear.
  assign clr       = i_fifo_clr | (i_fifo_en ^ fifo_en_q);
  assign pop       = o_tx_valid & i_tx_ready & ~clr;
  assign push      = i_wr_en & ~clr & ((level < eff_depth) | pop);
  assign dma_mode  = (i_dma_mode & i_fifo_en) ? DMA_MODE1 : DMA_MODE0;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (i_wr_data),
    .rdata (o_tx_data),
    .level (level)
  );

  assign next_level = clr ? '0 : (level + LW'(push) - LW'(pop));

  // Mode 1 holds the request between full and empty.
  always_comb begin
    txdrdyn_d = TXDRDYn;
    if (dma_mode == DMA_MODE0)      txdrdyn_d = (next_level != '0);
    else if (next_level == eff_depth) txdrdyn_d = 1'b1;
    else if (next_level == '0)       txdrdyn_d = 1'b0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      fifo_en_q     <= 1'b0;
      o_wr_overflow <= 1'b0;
      TXDRDYn       <= 1'b0;
    end else begin
      fifo_en_q     <= i_fifo_en;
      o_wr_overflow <= i_wr_en & ~clr & ~push;
      TXDRDYn       <= txdrdyn_d;
    end
  end

  assign o_level         = level;
  assign o_tx_valid      = (level != '0);
  assign o_tx_fifo_empty = (level == '0);
  assign o_tx_empty      = o_tx_fifo_empty & ~i_tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       i_wr_en = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_fifo_en = 1'b0;
  logic       i_fifo_clr = 1'b0;
  logic       i_dma_mode = 1'b0;
  logic       i_tx_ready = 1'b0;
  logic       i_tx_busy = 1'b0;
  logic       o_tx_valid;
  logic [7:0] o_tx_data;
  logic [4:0] o_level;
  logic       o_tx_fifo_empty;
  logic       o_tx_empty;
  logic       o_wr_overflow;
  logic       TXDRDYn;

  uart_tx_fifo dut (
    .PCLK            (PCLK),
    .PRESETn         (PRESETn),
    .i_wr_en         (i_wr_en),
    .i_wr_data       (i_wr_data),
    .i_fifo_en       (i_fifo_en),
    .i_fifo_clr      (i_fifo_clr),
    .i_dma_mode      (i_dma_mode),
    .i_tx_ready      (i_tx_ready),
    .i_tx_busy       (i_tx_busy),
    .o_tx_valid      (o_tx_valid),
    .o_tx_data       (o_tx_data),
    .o_level         (o_level),
    .o_tx_fifo_empty (o_tx_fifo_empty),
    .o_tx_empty      (o_tx_empty),
    .o_wr_overflow   (o_wr_overflow),
    .TXDRDYn         (TXDRDYn)
  );

  always #5 PCLK = ~PCLK;

  int passed = 0;
  int total  = 0;

  logic [7:0] mq[$];
  logic       m_txd;
  logic       m_ovf;
  logic       m_fen_prev;
  logic [7:0] drained[$];

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       fen;
    logic       clr;
    logic       dma;
    logic       rdy;
    logic [4:0] e_level;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_ovf;
    logic       e_txd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    mq.delete();
    m_txd = 1'b0;
    m_ovf = 1'b0;
    m_fen_prev = 1'b0;
  endfunction

  // Queue-level reference: capacity, clear and DMA rules stated directly.
  function automatic void model_step();
    int  cap;
    bit  clear, pop, accept;
    cap   = i_fifo_en ? 16 : 1;
    clear = i_fifo_clr || (i_fifo_en != m_fen_prev);
    pop   = (mq.size() > 0) && i_tx_ready;
    if (clear) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      accept = i_wr_en && ((mq.size() < cap) || pop);
      if (pop) void'(mq.pop_front());
      if (accept) mq.push_back(i_wr_data);
      m_ovf = i_wr_en && !accept;
    end
    if (!(i_dma_mode && i_fifo_en)) m_txd = (mq.size() != 0);
    else if (mq.size() == cap)      m_txd = 1'b1;
    else if (mq.size() == 0)        m_txd = 1'b0;
    m_fen_prev = i_fifo_en;
  endfunction

  task automatic compare_model();
    logic [7:0] hd;
    bit         emp;
    emp = (mq.size() == 0);
    hd  = emp ? 8'h00 : mq[0];
    chk("model", {o_level, o_tx_valid, o_tx_data, o_tx_fifo_empty, o_tx_empty, o_wr_overflow, TXDRDYn},
        {5'(mq.size()), !emp, hd, emp, emp && !i_tx_busy, m_ovf, m_txd});
  endtask

  task automatic cyc(input logic wr, input logic [7:0] d);
    i_wr_en = wr;
    i_wr_data = d;
    if (o_tx_valid && i_tx_ready) drained.push_back(o_tx_data);
    @(posedge PCLK);
    model_step();
    @(negedge PCLK);
    i_wr_en = 1'b0;
    i_fifo_clr = 1'b0;
    compare_model();
  endtask

  task automatic chk_reset(input string name);
    chk(name, {o_level, o_tx_valid, o_tx_data, o_tx_fifo_empty, o_tx_empty, o_wr_overflow, TXDRDYn},
        {5'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic fen, input logic clr,
                              input logic dma, input logic rdy, input logic [4:0] el, input logic ev,
                              input logic [7:0] ed, input logic eo, input logic et);
    vec_t v;
    v.wr = wr; v.d = d; v.fen = fen; v.clr = clr; v.dma = dma; v.rdy = rdy;
    v.e_level = el; v.e_valid = ev; v.e_data = ed; v.e_ovf = eo; v.e_txd = et;
    return v;
  endfunction

  initial begin
    model_reset();
    #2;
    chk_reset("reset");
    @(negedge PCLK);
    PRESETn = 1'b1;

    //         wr  d      fen clr dma rdy  lvl valid data  ovf txd
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 5'd0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h55, 1, 0, 0, 0, 5'd1, 1, 8'h55, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 5'd0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 5'd0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 0, 5'd1, 1, 8'h11, 0, 1));
    vecs.push_back(mk(1, 8'h22, 0, 0, 0, 0, 5'd1, 1, 8'h11, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 5'd1, 1, 8'h11, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 5'd0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h33, 0, 0, 0, 0, 5'd1, 1, 8'h33, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 5'd0, 0, 8'h00, 0, 0));
    for (int k = 0; k < vecs.size(); k++) begin
      i_fifo_en  = vecs[k].fen;
      i_fifo_clr = vecs[k].clr;
      i_dma_mode = vecs[k].dma;
      i_tx_ready = vecs[k].rdy;
      cyc(vecs[k].wr, vecs[k].d);
      chk($sformatf("vec%0d", k), {o_level, o_tx_valid, o_tx_data, o_wr_overflow, TXDRDYn},
          {vecs[k].e_level, vecs[k].e_valid, vecs[k].e_data, vecs[k].e_ovf, vecs[k].e_txd});
    end

    // Fill to full, overflow once, drain in order.
    i_fifo_en = 1; i_dma_mode = 0; i_tx_ready = 0;
    for (int i = 0; i < 16; i++) cyc(1, 8'(i));
    cyc(1, 8'hAA);
    chk("t2_ovf", o_wr_overflow, 1);
    chk("t2_level", o_level, 16);
    cyc(0, 0);
    chk("t2_ovf_once", o_wr_overflow, 0);
    drained.delete();
    i_tx_ready = 1;
    repeat (18) cyc(0, 0);
    chk("t2_count", drained.size(), 16);
    for (int i = 0; i < 16 && i < drained.size(); i++) chk($sformatf("t2_byte%0d", i), drained[i], i);

    // Full with simultaneous write and pop.
    i_tx_ready = 0;
    for (int i = 0; i < 16; i++) cyc(1, 8'(i));
    drained.delete();
    i_tx_ready = 1;
    cyc(1, 8'h77);
    chk("t3_level", o_level, 16);
    chk("t3_ovf", o_wr_overflow, 0);
    repeat (18) cyc(0, 0);
    chk("t3_count", drained.size(), 17);
    if (drained.size() == 17) chk("t3_last", drained[16], 8'h77);

    // DMA mode 1 hysteresis.
    i_tx_ready = 0; i_dma_mode = 1;
    cyc(0, 0);
    cyc(1, 8'h01);
    chk("t4_one", TXDRDYn, 0);
    for (int i = 0; i < 15; i++) cyc(1, 8'(i + 2));
    chk("t4_full_lvl", o_level, 16);
    chk("t4_full", TXDRDYn, 1);
    i_tx_ready = 1;
    cyc(0, 0);
    i_tx_ready = 0;
    chk("t4_pop1", TXDRDYn, 1);
    i_tx_ready = 1;
    repeat (15) cyc(0, 0);
    chk("t4_empty_lvl", o_level, 0);
    chk("t4_empty", TXDRDYn, 0);

    // Clear beats a same-cycle write, then TEMT and async reset.
    i_tx_ready = 0; i_dma_mode = 0;
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h80 + i));
    chk("t6_lvl5", o_level, 5);
    i_fifo_clr = 1;
    cyc(1, 8'h99);
    chk("t6_clr", {o_level, o_tx_valid, o_wr_overflow}, {5'd0, 1'b0, 1'b0});
    cyc(0, 0);
    chk("t6_no_ovf", o_wr_overflow, 0);
    i_tx_busy = 1; #1;
    chk("t6_temt_busy", o_tx_empty, 0);
    i_tx_busy = 0; #1;
    chk("t6_temt_idle", o_tx_empty, 1);
    @(negedge PCLK);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hC0 + i));
    i_tx_ready = 1;
    cyc(0, 0);
    #2 PRESETn = 0;
    #1 chk_reset("t6_async_reset");
    model_reset();
    @(negedge PCLK);
    PRESETn = 1;
    i_tx_ready = 0;
    cyc(0, 0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(99) < 2) i_fifo_en = ~i_fifo_en;
      if ($urandom_range(99) < 5) i_dma_mode = ~i_dma_mode;
      i_fifo_clr = ($urandom_range(99) < 3);
      i_tx_ready = ($urandom_range(99) < 40);
      i_tx_busy  = $urandom_range(1);
      cyc($urandom_range(99) < 60, 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
